mont_redc256_serial: RTL

MONT_REDC256_SERIAL -- requirements
Module: mont_redc256_serial

---
 rtl/mont_redc256_serial.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mont_redc256_serial.sv
// Bit-serial 256-bit Montgomery reduction: res = t * 2^-256 mod n, STEP iterations per clock.
// Optional macro MONT_REDC_ODD_CHECK_EN flags an even modulus at accept (err=1, res=0).
module mont_redc256_serial #(
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] t,
  input  logic [255:0] n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] res,
  output logic         err
);

  localparam int RUN_CYCLES = 256 / STEP;

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4)) begin : g_bad_step
      $error("mont_redc256_serial: STEP must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, FSUB, DONE} state_t;

  state_t       state, state_nxt;
  logic [512:0] acc, acc_nxt;
  logic [255:0] nreg;
  logic [7:0]   cnt;
  logic [513:0] iter_sum;
  logic [513:0] diff;
  logic [255:0] res_fsub;
  logic         accept, last_iter, even_n;

  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == 8'(RUN_CYCLES - 1));

`ifdef MONT_REDC_ODD_CHECK_EN
  logic err_q;
  assign even_n = ~n[0];
  assign err    = err_q;
`else
  assign even_n = 1'b0;
  assign err    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = even_n ? DONE : RUN;
      RUN:  if (last_iter) state_nxt = FSUB;
      FSUB:                state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // One REDC step: make ACC even by adding n when odd, then halve; chained STEP times.
  always_comb begin
    acc_nxt  = acc;
    iter_sum = '0;
    for (int i = 0; i < STEP; i++) begin
      iter_sum = {1'b0, acc_nxt} + (acc_nxt[0] ? {258'b0, nreg} : 514'b0);
      acc_nxt  = iter_sum[513:1];
    end
  end

  // Post-RUN value is below 2n, so a single conditional subtract fully reduces it.
  always_comb begin
    diff     = {1'b0, acc} - {258'b0, nreg};
    res_fsub = diff[513] ? acc[255:0] : diff[255:0];
  end

  // NOTE: acc and nreg are pure datapath, always loaded at accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      acc  <= {1'b0, t};
      nreg <= n;
    end else if (state == RUN) begin
      acc  <= acc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      res <= '0;
`ifdef MONT_REDC_ODD_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt <= '0;
`ifdef MONT_REDC_ODD_CHECK_EN
          if (even_n) begin
            res   <= '0;
            err_q <= 1'b1;
          end
`endif
        end
        RUN:  cnt <= cnt + 8'd1;
        FSUB: res <= res_fsub;
        DONE: begin
`ifdef MONT_REDC_ODD_CHECK_EN
          if (out_ready) err_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
